// File: rtl/bus_pkg.sv
// Shared types and widths for the burst bus subordinate.
package bus_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic {RESP_OKAY = 1'b0, RESP_ERR = 1'b1} resp_e;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} sub_state_e;

    function automatic resp_e range_resp(input logic in_range);
        return in_range ? RESP_OKAY : RESP_ERR;
    endfunction
endpackage

// File: rtl/bus_sub_mem.sv
// Purpose: DEPTH x DATA_W word store for the subordinate.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none, accepts a write every cycle.
module bus_sub_mem
    import bus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/bus_subordinate.sv
// Purpose: burst bus responder over a local word memory; BUS_SUB_WAIT_STATE_EN adds WAIT_CYC idle cycles per beat.
// Latency: ready rises 1 cycle after valid is sampled (WAIT_CYC+1 with wait states).
// Backpressure: paces beats with ready; dropping valid mid-burst aborts to IDLE.
module bus_subordinate
    import bus_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int BLEN_W   = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BLEN_W-1:0] burst_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              resp
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sub_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [BLEN_W-1:0] beat_cnt;
    logic [BLEN_W-1:0] len_lat;
    logic              wr_lat;
    logic              last_beat;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              mem_wr_vld;
    logic [DATA_W-1:0] mem_rd_dat;
    logic [DATA_W-1:0] rd_word;
    resp_e             rd_resp;

`ifdef BUS_SUB_WAIT_STATE_EN
    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    logic [WAIT_W-1:0] wait_cnt;
`else
    logic [31:0] unused_wait_cyc;
    assign unused_wait_cyc = WAIT_CYC;
`endif

    // Read side looks ahead: at burst start it fetches addr, afterwards the next beat.
    assign next_ptr    = ptr + 1'b1;
    assign rd_ptr      = (state == IDLE) ? addr : next_ptr;
    assign wr_in_range = int'(ptr) < DEPTH;
    assign rd_in_range = int'(rd_ptr) < DEPTH;
    assign last_beat   = beat_cnt == len_lat - 1'b1;
    assign mem_wr_vld  = (state == BEAT) && valid && wr_lat && wr_in_range;
    assign rd_word     = rd_in_range ? mem_rd_dat : '0;
    assign rd_resp     = range_resp(rd_in_range);

    bus_sub_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_vld  (mem_wr_vld),
        .wr_addr (ptr[MEM_AW-1:0]),
        .wr_dat  (wdata),
        .rd_addr (rd_ptr[MEM_AW-1:0]),
        .rd_dat  (mem_rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b0;
            rdata    <= '0;
            resp     <= 1'b0;
            ptr      <= '0;
            beat_cnt <= '0;
            len_lat  <= '0;
            wr_lat   <= 1'b0;
`ifdef BUS_SUB_WAIT_STATE_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        ptr      <= addr;
                        wr_lat   <= wr_en;
                        len_lat  <= (burst_len == '0) ? BLEN_W'(1) : burst_len;
                        beat_cnt <= '0;
                        rdata    <= rd_word;
                        resp     <= rd_resp;
`ifdef BUS_SUB_WAIT_STATE_EN
                        state    <= WAIT;
                        wait_cnt <= '0;
`else
                        state    <= BEAT;
                        ready    <= 1'b1;
`endif
                    end
                end
`ifdef BUS_SUB_WAIT_STATE_EN
                WAIT: begin
                    if (!valid) begin
                        state <= IDLE;
                        rdata <= '0;
                        resp  <= 1'b0;
                    end else if (wait_cnt == WAIT_W'(WAIT_CYC - 1)) begin
                        state <= BEAT;
                        ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
`endif
                BEAT: begin
                    if (!valid) begin
                        state <= IDLE;
                        ready <= 1'b0;
                        rdata <= '0;
                        resp  <= 1'b0;
                    end else begin
                        ptr      <= next_ptr;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= DONE;
                            ready <= 1'b0;
                            rdata <= '0;
                            resp  <= 1'b0;
                        end else begin
                            rdata <= rd_word;
                            resp  <= rd_resp;
`ifdef BUS_SUB_WAIT_STATE_EN
                            state    <= WAIT;
                            ready    <= 1'b0;
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    // A still-high valid must not start another burst.
                    if (!valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_subordinate.sv
// Bench for bus_subordinate: directed vector table, reset/abort sequences and random bursts vs a word-array model.
module tb_bus_subordinate;
    localparam int TB_DEPTH = 64;
    localparam int TB_WAIT  = 2;
`ifdef BUS_SUB_WAIT_STATE_EN
    localparam int GAP = TB_WAIT + 1;
`else
    localparam int GAP = 1;
`endif
    localparam int NVEC = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [3:0]  burst_len = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        resp;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem   [256];
    bit          ref_known [256];
    logic [31:0] bdata     [16];
    logic [31:0] obs_rdata [16];
    logic        obs_resp  [16];
    int          obs_gap   [16];

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [3:0]  len;
        int          abort_n;
        int          hold;
        logic [31:0] w [4];
        int          exp_beats;
        int          exp_err;
    } vec_t;
    vec_t vt [NVEC];

    bus_subordinate #(
        .DEPTH    (TB_DEPTH),
        .BLEN_W   (4),
        .WAIT_CYC (TB_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .wr_en     (wr_en),
        .addr      (addr),
        .burst_len (burst_len),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .resp      (resp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input bit wr, input logic [7:0] a, input logic [3:0] len,
                           input int abort_n, input int hold, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int eb, input int ee);
        vt[k].wr = wr; vt[k].a = a; vt[k].len = len; vt[k].abort_n = abort_n; vt[k].hold = hold;
        vt[k].w[0] = w0; vt[k].w[1] = w1; vt[k].w[2] = w2; vt[k].w[3] = w3;
        vt[k].exp_beats = eb; vt[k].exp_err = ee;
    endtask

    // Drives one burst from an idle bus; side inputs are scrambled once the burst is latched.
    task automatic run_burst(input bit wr, input logic [7:0] a, input logic [3:0] len,
                             input int abort_n, input int hold, output int nb);
        int  cyc, last_cyc, want;
        bit  aborted;
        want    = (len == 0) ? 1 : int'(len);
        aborted = (abort_n >= 0) && (abort_n < want);
        if (aborted) want = abort_n;
        nb = 0; cyc = 0; last_cyc = 0;
        @(negedge clk);
        valid = 1'b1; wr_en = wr; addr = a; burst_len = len; wdata = bdata[0];
        while (nb < want && cyc < 200) begin
            @(negedge clk);
            cyc++;
            wdata     = bdata[nb];
            addr      = 8'($urandom);
            burst_len = 4'($urandom);
            wr_en     = 1'($urandom);
            if (ready) begin
                obs_rdata[nb] = rdata;
                obs_resp[nb]  = resp;
                obs_gap[nb]   = cyc - last_cyc;
                last_cyc      = cyc;
                nb++;
            end
        end
        if (nb < want) chk("beat_timeout", nb, want);
        @(negedge clk);
        if (aborted) begin
            valid = 1'b0;
            @(negedge clk);
            chk("abort_ready", 32'(ready), 0);
        end else begin
            chk("ready_after_last", 32'(ready), 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk($sformatf("done_hold[%0d]", h), 32'(ready), 0);
            end
            valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Compares observed beats against the word-array model and updates it for writes.
    task automatic score(input bit wr, input logic [7:0] a, input int nb, input string tag, output int errs);
        logic [7:0] pa;
        bit         inr;
        errs = 0;
        for (int i = 0; i < nb; i++) begin
            pa  = a + 8'(i);
            inr = int'(pa) < TB_DEPTH;
            if (obs_resp[i]) errs++;
            chk($sformatf("%s resp[%0d]", tag, i), 32'(obs_resp[i]), 32'(!inr));
            chk($sformatf("%s gap[%0d]", tag, i), obs_gap[i], GAP);
            if (wr) begin
                if (inr) begin
                    ref_mem[pa]   = bdata[i];
                    ref_known[pa] = 1'b1;
                end
            end else if (!inr || ref_known[pa]) begin
                chk($sformatf("%s rdata[%0d]", tag, i), obs_rdata[i], inr ? ref_mem[pa] : 32'h0);
            end
        end
    endtask

    initial begin
        int nb, errs, seen, cyc, len_eff, ab;
        bit wr;
        logic [7:0] a;
        logic [3:0] len;

        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end

        set_vec(0,  1, 8'h20, 4'd4, -1, 0, 32'hDEADBEEF, 32'hBEEFCAFE, 32'h12345678, 32'hA5A55A5A, 4, 0);
        set_vec(1,  0, 8'h20, 4'd4, -1, 0, 0, 0, 0, 0, 4, 0);
        set_vec(2,  1, 8'h3E, 4'd4, -1, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 2);
        set_vec(3,  0, 8'h3E, 4'd4, -1, 0, 0, 0, 0, 0, 4, 2);
        set_vec(4,  1, 8'h10, 4'd8, -1, 0, 32'h0A000000, 32'h0A000001, 32'h0A000002, 32'h0A000003, 8, 0);
        set_vec(5,  1, 8'h10, 4'd8,  3, 0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 3, 0);
        set_vec(6,  0, 8'h10, 4'd4, -1, 0, 0, 0, 0, 0, 4, 0);
        set_vec(7,  1, 8'h04, 4'd3, -1, 0, 32'h44440004, 32'h44440005, 32'h44440006, 32'h0, 3, 0);
        set_vec(8,  1, 8'h05, 4'd0, -1, 3, 32'h55555555, 32'h66666666, 32'h77777777, 32'h0, 1, 0);
        set_vec(9,  0, 8'h04, 4'd3, -1, 0, 0, 0, 0, 0, 3, 0);
        set_vec(10, 1, 8'hFE, 4'd4, -1, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h01010101, 32'h02020202, 4, 2);
        set_vec(11, 0, 8'hFF, 4'd3, -1, 0, 0, 0, 0, 0, 3, 1);
        set_vec(12, 0, 8'h3F, 4'd1, -1, 0, 0, 0, 0, 0, 1, 0);
        set_vec(13, 0, 8'h40, 4'd1, -1, 0, 0, 0, 0, 0, 1, 1);
        set_vec(14, 0, 8'h21, 4'd3, -1, 0, 0, 0, 0, 0, 3, 0);

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(ready), 0);
        chk("reset rdata", rdata, 0);
        chk("reset resp", 32'(resp), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle ready", 32'(ready), 0);

        for (int k = 0; k < NVEC; k++) begin
            for (int i = 0; i < 16; i++)
                bdata[i] = (i < 4) ? vt[k].w[i] : vt[k].w[0] + 32'(i) * 32'h00010001;
            run_burst(vt[k].wr, vt[k].a, vt[k].len, vt[k].abort_n, vt[k].hold, nb);
            chk($sformatf("vec%0d beats", k), nb, vt[k].exp_beats);
            score(vt[k].wr, vt[k].a, nb, $sformatf("vec%0d", k), errs);
            chk($sformatf("vec%0d err_beats", k), errs, vt[k].exp_err);
        end

        // Reset asserted while the second beat of a read is presented.
        @(negedge clk);
        valid = 1'b1; wr_en = 1'b0; addr = 8'h20; burst_len = 4'd4;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready) seen++;
        end
        chk("rst_mid beats_seen", seen, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid ready", 32'(ready), 0);
        chk("rst_mid rdata", rdata, 0);
        chk("rst_mid resp", 32'(resp), 0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(1'b0, 8'h22, 4'd1, -1, 0, nb);
        chk("post_rst beats", nb, 1);
        score(1'b0, 8'h22, nb, "post_rst", errs);

        for (int r = 0; r < 40; r++) begin
            wr  = 1'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 72));
            len = 4'($urandom_range(0, 15));
            len_eff = (len == 0) ? 1 : int'(len);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len_eff) : -1;
            for (int i = 0; i < 16; i++) bdata[i] = $urandom;
            run_burst(wr, a, len, ab, $urandom_range(0, 2), nb);
            chk($sformatf("rnd%0d beats", r), nb, (ab >= 0 && ab < len_eff) ? ab : len_eff);
            score(wr, a, nb, $sformatf("rnd%0d", r), errs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
